div_seq_unit: RTL and testbench
===============================

# div_seq_unit

Multi-cycle radix-2 restoring divider for the MIPS multi-cycle CPU, executing DIV/DIVU. It sits directly upstream of the HI/LO write-data selection.
- `remainder` drives the HI write-data DIV input.
- `quotient` drives the corresponding LO path.

The control unit starts it with a one-cycle pulse, stalls on `busy`, and asserts the HI/LO DIV select and write enables in the cycle `done` is high.

## Interface
- No parameters; data width fixed at 32.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `is_signed`  in  1  1 = DIV, 0 = DIVU; latched with `start`.
- `dividend`  in  32  rs operand; latched with `start`.
- `divisor`  in  32  rt operand; latched with `start`.
- `busy`  out  1  high throughout CALC.
- `done`  out  1  one-cycle pulse; results valid.
- `quotient`  out  32  registered quotient (LO).
- `remainder`  out  32  registered remainder (HI).
- `div_by_zero`  out  1  registered; set when the latched divisor was 0.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `start`=1 → latch operands, load the 6-bit iteration counter with 0, go to CALC.
  - Otherwise stay in IDLE.
- CALC:
  - Each cycle, shift the {partial remainder, quotient} register left one bit.
  - Trial-subtract the divisor magnitude. If non-negative, keep the difference and set quotient LSB to 1.
  - Increment the counter. After the 32nd iteration (counter = 31), go to DONE.
  - `start` is ignored in CALC.
- DONE:
  - `done`=1 for exactly one cycle; go to IDLE.
  - If `start`=1 in DONE, the new operation is accepted (back-to-back) and the next state is CALC.
- Signed mode (`is_signed`=1):
  - Divide operand magnitudes (absolute values, 33-bit safe).
  - Quotient is negated when operand signs differ.
  - Remainder takes the sign of the dividend.
- Overflow case: 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0 (two's-complement wrap, no flag).
- Divide by zero, either mode:
  - Quotient 0xFFFFFFFF, remainder = original dividend, `div_by_zero`=1.
  - Same latency as a normal divide; no exception is raised.
- Output registers:
  - `quotient`, `remainder` and `div_by_zero` update only on the CALC→DONE transition.
  - They hold until the next CALC→DONE transition, including while a later operation is in CALC.

## Timing
- Reset value of every output is 0: `busy`, `done`, `quotient`, `remainder`, `div_by_zero`. State resets to IDLE; the counter and internal registers reset to 0.
- Cycle numbering: cycle 0 is the edge where `start` is sampled.
- `busy` is high in cycles 1–32. The CALC→DONE edge ends cycle 32.
- `done` is high in cycle 33, with results already valid in that cycle.
- Total latency: start-to-done is 33 cycles. With back-to-back issue, `start` in DONE gives a throughput of one divide per 33 cycles.
- `busy` is low in IDLE and DONE.
- `done` and `busy` are never high in the same cycle.
- Reset asserted mid-CALC:
  - Immediate (asynchronous) return to IDLE and all outputs to 0.
  - No `done` is produced for the aborted operation.
- Operand inputs may change freely after the `start` cycle; they are never re-sampled during CALC.

## Configuration
- Macro: `DIV_SIGNED_EN`.
- Defined:
  - Signed path is compiled in; `is_signed` selects DIV or DIVU as described above.
- Undefined:
  - Sign logic, magnitude conversion and result negation are removed.
  - `is_signed` is ignored and every operation is unsigned (DIVU).
  - Latency, handshake and divide-by-zero behaviour are unchanged.

## Test plan
- Unsigned 100 / 7 (`is_signed`=0), `start` in cycle 0 → `busy` in cycles 1–32; `done` in cycle 33; quotient 14, remainder 2, `div_by_zero` 0.
- Signed 0xFFFFFFF9 (−7) / 2:
  - With `DIV_SIGNED_EN` → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - Without `DIV_SIGNED_EN` → quotient 0x7FFFFFFC, remainder 1.
- Boundary divides:
  - 5 / 0 → quotient 0xFFFFFFFF, remainder 5, `div_by_zero` 1, `done` at cycle 33.
  - Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Handshake:
  - `start` pulsed again in cycle 10 with different operands → ignored; first result delivered unchanged at cycle 33.
  - `start` in the `done` cycle with 9 / 4 → busy next cycle; quotient 2, remainder 1 at cycle 66.
- `rst_n` driven low in cycle 15 of a divide → `busy` drops to 0 without waiting for a clock edge; all outputs 0; no `done`.
  - After release, a new 100 / 7 completes normally in 33 cycles.

Source files
------------

// File: rtl/div_seq_unit.sv
// div_seq_unit: 32-bit radix-2 restoring divider for DIV/DIVU, 33-cycle latency.
// Optional signed path compiled in with `define DIV_SIGNED_EN.
module div_seq_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic [31:0] r_dvd;
  logic        r_dbz;

  logic        w_accept;
  logic        w_last;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [31:0] w_q_nxt;
  logic [31:0] w_r_nxt;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q_fin;
  logic [31:0] w_r_fin;

  assign w_accept = start && (r_state != S_CALC);
  assign w_last   = (r_state == S_CALC) && (r_cnt == 6'd31);

  // partial remainder never exceeds the divisor, so 33 bits
  // after the shift are enough for the trial subtract
  assign w_shift  = {r_rem, r_quo[31]};
  assign w_ge     = w_shift >= {1'b0, r_dvs};
  assign w_sub    = w_shift[31:0] - r_dvs;
  assign w_r_nxt  = w_ge ? w_sub : w_shift[31:0];
  assign w_q_nxt  = {r_quo[30:0], w_ge};

`ifdef DIV_SIGNED_EN
  logic w_a_neg;
  logic w_b_neg;
  logic r_neg_q;
  logic r_neg_r;

  assign w_a_neg = is_signed & dividend[31];
  assign w_b_neg = is_signed & divisor[31];
  assign w_a_mag = w_a_neg ? (~dividend + 32'd1) : dividend;
  assign w_b_mag = w_b_neg ? (~divisor + 32'd1) : divisor;
  assign w_q_fin = r_neg_q ? (~w_q_nxt + 32'd1) : w_q_nxt;
  assign w_r_fin = r_neg_r ? (~w_r_nxt + 32'd1) : w_r_nxt;

  // result sign fixups captured with the operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end
  end
`else
  logic w_unused;

  assign w_unused = is_signed;
  assign w_a_mag  = dividend;
  assign w_b_mag  = divisor;
  assign w_q_fin  = w_q_nxt;
  assign w_r_fin  = w_r_nxt;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (r_cnt == 6'd31) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? S_CALC : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // operand latch, iteration datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 6'd0;
      r_rem       <= 32'd0;
      r_quo       <= 32'd0;
      r_dvs       <= 32'd0;
      r_dvd       <= 32'd0;
      r_dbz       <= 1'b0;
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= 6'd0;
      r_rem <= 32'd0;
      r_quo <= w_a_mag;
      r_dvs <= w_b_mag;
      r_dvd <= dividend;
      r_dbz <= (divisor == 32'd0);
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + 6'd1;
      r_rem <= w_r_nxt;
      r_quo <= w_q_nxt;
      if (w_last) begin
        quotient    <= r_dbz ? 32'hFFFF_FFFF : w_q_fin;
        remainder   <= r_dbz ? r_dvd : w_r_fin;
        div_by_zero <= r_dbz;
      end
    end
  end

endmodule

// File: tb/tb_div_seq_unit.sv
// tb_div_seq_unit: vector table, random ops vs arithmetic model,
// and handshake / reset corner sequences for div_seq_unit.
module tb_div_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  div_seq_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic s, output logic [31:0] q,
                                output logic [31:0] r, output logic z);
    logic   sg;
    longint sa;
    longint sb;
`ifdef DIV_SIGNED_EN
    sg = s;
`else
    sg = 1'b0 & s;
`endif
    z = (b == 32'd0);
    if (z) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // called just after a negedge; start is sampled on the next posedge
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic s);
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom);
  endtask

  // counts cycles after the start edge; returns at negedge of done cycle
  task automatic wait_done(input int poke, input logic hold_chk,
                           input logic [31:0] hq, input logic [31:0] hr,
                           output int lat);
    logic busy_bad;
    logic exp_b;
    lat      = -1;
    busy_bad = 1'b0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (k == poke + 1 && poke > 0) start = 1'b0;
      if (k == poke) begin
        start     = 1'b1;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        is_signed = 1'b0;
      end
      if (hold_chk && k == 5) begin
        chk("hold_q", quotient, hq);
        chk("hold_r", remainder, hr);
      end
      exp_b = (k <= 32);
      if (busy !== exp_b || (busy && done)) busy_bad = 1'b1;
      if (done === 1'b1) lat = k;
    end
    chk("busy_profile", 32'(busy_bad), 32'd0);
  endtask

  task automatic check_res(input string nm, input logic [31:0] eq,
                           input logic [31:0] er, input logic ez,
                           input int lat);
    chk({nm, "_lat"}, 32'(lat), 32'd33);
    chk({nm, "_q"}, quotient, eq);
    chk({nm, "_r"}, remainder, er);
    chk({nm, "_z"}, 32'(div_by_zero), 32'(ez));
  endtask

  task automatic run_one(input string nm, input logic [31:0] a,
                         input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic ez);
    int lat;
    @(negedge clk);
    issue(a, b, s);
    wait_done(0, 1'b0, 32'd0, 32'd0, lat);
    check_res(nm, eq, er, ez, lat);
  endtask

  vec_t vt[8];

  initial begin
    int          lat;
    int          dn;
    logic [31:0] a, b, mq, mr;
    logic        s, mz;

    vt[0] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0};
`ifdef DIV_SIGNED_EN
    vt[1] = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vt[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0};
    vt[3] = '{32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0};
`else
    vt[1] = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0};
    vt[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0};
    vt[3] = '{32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7, 1'b0};
`endif
    vt[4] = '{32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1};
    vt[5] = '{32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1};
    vt[6] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0};
    vt[7] = '{32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0};

    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    #22;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_z", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_one($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].s,
              vt[i].q, vt[i].r, vt[i].z);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(3, 0))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(15, 1));
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(3, 0));
        default: b = $urandom;
      endcase
      s = 1'($urandom);
      model(a, b, s, mq, mr, mz);
      run_one($sformatf("rnd%0d", i), a, b, s, mq, mr, mz);
    end

    // start during CALC must be ignored
    @(negedge clk);
    issue(32'd100, 32'd7, 1'b0);
    wait_done(10, 1'b0, 32'd0, 32'd0, lat);
    check_res("ignore_start", 32'd14, 32'd2, 1'b0, lat);

    // back-to-back: start in the done cycle, results hold meanwhile
    @(negedge clk);
    issue(32'd1000, 32'd10, 1'b0);
    wait_done(0, 1'b0, 32'd0, 32'd0, lat);
    check_res("b2b_first", 32'd100, 32'd0, 1'b0, lat);
    issue(32'd9, 32'd4, 1'b0);
    wait_done(0, 1'b1, 32'd100, 32'd0, lat);
    check_res("b2b_second", 32'd2, 32'd1, 1'b0, lat);

    // asynchronous reset in cycle 15
    @(negedge clk);
    issue(32'd100, 32'd7, 1'b0);
    repeat (15) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_q", quotient, 32'd0);
    chk("arst_r", remainder, 32'd0);
    chk("arst_z", 32'(div_by_zero), 32'd0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst_n = 1'b1;
    repeat (35) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("arst_no_done", 32'(dn), 32'd0);
    run_one("post_rst", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
